// File: rtl/trap_pkg.sv
// Shared encodings for the trap sequencer: trap codes, mcause values,
// machine-mode CSR addresses and FSM state constants.
package trap_pkg;

    // Trap codes presented by the exception detection logic
    localparam logic [2:0] TS_NONE                   = 3'd0;
    localparam logic [2:0] TS_EBREAK                 = 3'd1;
    localparam logic [2:0] TS_ECALL                  = 3'd2;
    localparam logic [2:0] TS_MISALIGNED_INSTRUCTION = 3'd3;
    localparam logic [2:0] TS_MISALIGNED_LOAD        = 3'd4;
    localparam logic [2:0] TS_MISALIGNED_STORE       = 3'd5;
    localparam logic [2:0] TS_MRET                   = 3'd6;
    localparam logic [2:0] TS_FENCEI                 = 3'd7;

    // Architectural mcause exception codes
    localparam int unsigned MCAUSE_MISALIGNED_INSTRUCTION = 0;
    localparam int unsigned MCAUSE_BREAKPOINT             = 3;
    localparam int unsigned MCAUSE_MISALIGNED_LOAD        = 4;
    localparam int unsigned MCAUSE_MISALIGNED_STORE       = 6;
    localparam int unsigned MCAUSE_ECALL                  = 11;

    // Machine-mode CSR addresses touched by the sequencer
    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    // Sequencer states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WR_MEPC   = 3'd1;
    localparam state_t ST_WR_MCAUSE = 3'd2;
    localparam state_t ST_RD_MTVEC  = 3'd3;
    localparam state_t ST_RD_MEPC   = 3'd4;
    localparam state_t ST_REDIRECT  = 3'd5;
    localparam state_t ST_RESUME    = 3'd6;

endpackage

// File: rtl/trap_cause_encoder.sv
// Maps a held trap code to its XLEN-bit mcause value. Codes that are not
// exceptions (NONE, MRET, FENCEI) map to zero.
module trap_cause_encoder
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      trap_status,
    output logic [XLEN-1:0] mcause
);

    // Pure table lookup; zero-extended to the CSR width
    always_comb begin
        mcause = '0;
        case (trap_status)
            TS_MISALIGNED_INSTRUCTION: mcause = XLEN'(MCAUSE_MISALIGNED_INSTRUCTION);
            TS_EBREAK:                 mcause = XLEN'(MCAUSE_BREAKPOINT);
            TS_MISALIGNED_LOAD:        mcause = XLEN'(MCAUSE_MISALIGNED_LOAD);
            TS_MISALIGNED_STORE:       mcause = XLEN'(MCAUSE_MISALIGNED_STORE);
            TS_ECALL:                  mcause = XLEN'(MCAUSE_ECALL);
            default:                   mcause = '0;
        endcase
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap response sequencer. Accepts a registered trap request in IDLE and
// walks the CSR write/read steps needed before redirecting the PC. All
// outputs are decoded from the state and held registers only, so a low
// clk_enable freezes them along with the state.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    input  logic            trapped,
    input  logic [2:0]      trap_status,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] csr_read_data,
    output logic [11:0]     csr_trap_address,
    output logic            csr_write_enable,
    output logic [XLEN-1:0] csr_write_data,
    output logic            pipeline_stall,
    output logic            pipeline_flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] trap_target
);

    // Clears the two low bits: mepc and the direct-mode vector are word aligned
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state_q,  state_d;
    logic [2:0]      cause_q,  cause_d;
    logic [XLEN-1:0] pc_q,     pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] mcause_val;

    trap_cause_encoder #(.XLEN(XLEN)) u_cause_enc (
        .trap_status (cause_q),
        .mcause      (mcause_val)
    );

    // Next-state and held-register update; nothing moves without clk_enable
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        target_d = target_q;
        if (clk_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (trapped && trap_status != TS_NONE) begin
                        cause_d = trap_status;
                        pc_d    = trap_pc;
                        case (trap_status)
                            TS_MRET:   state_d = ST_RD_MEPC;
                            TS_FENCEI: begin
                                // pc_q is loading this same edge, so use trap_pc directly
                                target_d = trap_pc + XLEN'(4);
                                state_d  = ST_REDIRECT;
                            end
                            default:   state_d = ST_WR_MEPC;
                        endcase
                    end
                end
                ST_WR_MEPC:   state_d = ST_WR_MCAUSE;
                ST_WR_MCAUSE: state_d = ST_RD_MTVEC;
                ST_RD_MTVEC: begin
                    // Direct mode only: mode bits are discarded
                    target_d = csr_read_data & ALIGN_MASK;
                    state_d  = ST_REDIRECT;
                end
                ST_RD_MEPC: begin
                    target_d = csr_read_data & ALIGN_MASK;
                    state_d  = ST_REDIRECT;
                end
                ST_REDIRECT:  state_d = ST_RESUME;
                // One dead cycle so the stale detector register is not re-taken
                ST_RESUME:    state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        csr_trap_address = '0;
        csr_write_enable = 1'b0;
        csr_write_data   = '0;
        pipeline_stall   = 1'b0;
        pipeline_flush   = 1'b0;
        pc_redirect      = 1'b0;
        trap_target      = '0;
        case (state_q)
            ST_WR_MEPC: begin
                csr_trap_address = CSR_MEPC;
                csr_write_enable = 1'b1;
                csr_write_data   = pc_q & ALIGN_MASK;
                pipeline_stall   = 1'b1;
            end
            ST_WR_MCAUSE: begin
                csr_trap_address = CSR_MCAUSE;
                csr_write_enable = 1'b1;
                csr_write_data   = mcause_val;
                pipeline_stall   = 1'b1;
            end
            ST_RD_MTVEC: begin
                csr_trap_address = CSR_MTVEC;
                pipeline_stall   = 1'b1;
            end
            ST_RD_MEPC: begin
                csr_trap_address = CSR_MEPC;
                pipeline_stall   = 1'b1;
            end
            ST_REDIRECT: begin
                pipeline_stall   = 1'b1;
                pipeline_flush   = 1'b1;
                pc_redirect      = 1'b1;
                trap_target      = target_q;
            end
            default: ;
        endcase
    end

    // State and held registers; synchronous reset aborts any sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

endmodule
